// File: rtl/cache_tagmr_writer.sv
// ---------------------------------------------------------------------------
// cache_tagmr_writer
//
// Purpose:
//   Write-side controller for a bank of NUM_CELLS "must-read" cache cells.
//   Each accepted write is placed in the lowest-index free slot. The block
//   then drives a one-cycle chip-enable/write-enable pulse to that cell with
//   the write's tag and data. The slot stays occupied until the cell reports
//   that its contents have been read. Held data is never overwritten, and a
//   tag that is already in flight or held cannot be accepted a second time.
//
// Ports:
//   clk           - sole clock, all state changes on the rising edge
//   reset_n       - asynchronous, active-low reset
//   wr_valid_i    - producer offers a write
//   wr_ready_o    - block accepts the offered write this cycle
//   wr_tag_i      - tag of the offered write
//   wr_data_i     - data of the offered write
//   cell_ce_o     - per-cell chip enable, high only in the write cycle
//   cell_we_o     - per-cell write enable, high only in the write cycle
//   cell_tag_o    - tag broadcast to all cells (holds the last written tag)
//   cell_wdata_o  - data broadcast to all cells (holds the last written data)
//   cell_read_i   - per-cell "has been read" pulse from the cells
//   occupied_o    - per-slot flag: slot holds unread data (writing or held)
//   count_o       - number of occupied slots
//   full_o        - every slot is occupied
//   empty_o       - no slot is occupied
// ---------------------------------------------------------------------------
module cache_tagmr_writer #(
  parameter int DATA_WIDTH        = 16,
  parameter int TAG_ADDRESS_WIDTH = 8,
  parameter int NUM_CELLS         = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           wr_valid_i,
  output logic                           wr_ready_o,
  input  logic [TAG_ADDRESS_WIDTH-1:0]   wr_tag_i,
  input  logic [DATA_WIDTH-1:0]          wr_data_i,
  output logic [NUM_CELLS-1:0]           cell_ce_o,
  output logic [NUM_CELLS-1:0]           cell_we_o,
  output logic [TAG_ADDRESS_WIDTH-1:0]   cell_tag_o,
  output logic [DATA_WIDTH-1:0]          cell_wdata_o,
  input  logic [NUM_CELLS-1:0]           cell_read_i,
  output logic [NUM_CELLS-1:0]           occupied_o,
  output logic [$clog2(NUM_CELLS+1)-1:0] count_o,
  output logic                           full_o,
  output logic                           empty_o
);

  localparam int CW = $clog2(NUM_CELLS + 1);

  // Lifecycle of one slot: FREE -> WRITING (one cycle) -> HELD -> FREE.
  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_WRITING = 2'd1,
    SLOT_HELD    = 2'd2
  } slot_state_e;

  slot_state_e                  slot_state_q [NUM_CELLS];
  slot_state_e                  slot_state_d [NUM_CELLS];
  logic [TAG_ADDRESS_WIDTH-1:0] slot_tag_q   [NUM_CELLS];
  logic [TAG_ADDRESS_WIDTH-1:0] slot_tag_d   [NUM_CELLS];

  logic [NUM_CELLS-1:0]         cell_en_q, cell_en_d;
  logic [TAG_ADDRESS_WIDTH-1:0] cell_tag_q, cell_tag_d;
  logic [DATA_WIDTH-1:0]        cell_wdata_q, cell_wdata_d;
  logic [CW-1:0]                count_q, count_d;

  logic [NUM_CELLS-1:0] free_vec;
  logic [NUM_CELLS-1:0] occ_vec;
  logic [NUM_CELLS-1:0] dup_vec;
  logic [NUM_CELLS-1:0] freed_vec;
  logic [NUM_CELLS-1:0] alloc_vec;
  logic                 alloc_found;
  logic                 wr_ready;
  logic                 accept;
  logic [CW-1:0]        freed_cnt;

  // Slot status decode. Everything here looks only at registered state, so
  // wr_ready_o never depends combinationally on cell_read_i. A slot being
  // freed this cycle is still HELD: it is not yet available, and its tag
  // still blocks a duplicate.
  always_comb begin
    free_vec  = '0;
    occ_vec   = '0;
    dup_vec   = '0;
    freed_vec = '0;
    for (int k = 0; k < NUM_CELLS; k++) begin
      free_vec[k]  = (slot_state_q[k] == SLOT_FREE);
      occ_vec[k]   = (slot_state_q[k] != SLOT_FREE);
      dup_vec[k]   = occ_vec[k] && (slot_tag_q[k] == wr_tag_i);
      // Read pulses only count once the cell actually holds the data.
      freed_vec[k] = (slot_state_q[k] == SLOT_HELD) && cell_read_i[k];
    end
  end

  // Lowest-index free slot gets the next accepted write.
  always_comb begin
    alloc_vec   = '0;
    alloc_found = 1'b0;
    for (int k = 0; k < NUM_CELLS; k++) begin
      if (free_vec[k] && !alloc_found) begin
        alloc_vec[k] = 1'b1;
        alloc_found  = 1'b1;
      end
    end
  end

  assign wr_ready = alloc_found && (dup_vec == '0);
  assign accept   = wr_valid_i && wr_ready;

  // Number of slots released on this edge; several cells may report a read
  // in the same cycle.
  always_comb begin
    freed_cnt = '0;
    for (int k = 0; k < NUM_CELLS; k++) begin
      freed_cnt = freed_cnt + CW'(freed_vec[k]);
    end
  end

  // Next-state logic for the per-slot FSMs, the write pulse and the
  // occupancy counter.
  always_comb begin
    for (int k = 0; k < NUM_CELLS; k++) begin
      slot_state_d[k] = slot_state_q[k];
      slot_tag_d[k]   = slot_tag_q[k];
      case (slot_state_q[k])
        SLOT_FREE: begin
          if (accept && alloc_vec[k]) begin
            slot_state_d[k] = SLOT_WRITING;
            slot_tag_d[k]   = wr_tag_i;
          end
        end
        SLOT_WRITING: begin
          slot_state_d[k] = SLOT_HELD;
        end
        SLOT_HELD: begin
          if (cell_read_i[k]) begin
            slot_state_d[k] = SLOT_FREE;
          end
        end
        default: begin
          slot_state_d[k] = SLOT_FREE;
        end
      endcase
    end

    // The cell pulse is the registered allocation vector, so it lines up
    // exactly with the WRITING cycle of the chosen slot. Tag and data keep
    // their last values between writes.
    cell_en_d    = accept ? alloc_vec : '0;
    cell_tag_d   = accept ? wr_tag_i  : cell_tag_q;
    cell_wdata_d = accept ? wr_data_i : cell_wdata_q;

    count_d = count_q + CW'(accept) - freed_cnt;
  end

  // All state, including the write pulse, clears asynchronously so that a
  // reset during a write cycle drops the pulse at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CELLS; k++) begin
        slot_state_q[k] <= SLOT_FREE;
        slot_tag_q[k]   <= '0;
      end
      cell_en_q    <= '0;
      cell_tag_q   <= '0;
      cell_wdata_q <= '0;
      count_q      <= '0;
    end else begin
      for (int k = 0; k < NUM_CELLS; k++) begin
        slot_state_q[k] <= slot_state_d[k];
        slot_tag_q[k]   <= slot_tag_d[k];
      end
      cell_en_q    <= cell_en_d;
      cell_tag_q   <= cell_tag_d;
      cell_wdata_q <= cell_wdata_d;
      count_q      <= count_d;
    end
  end

  assign wr_ready_o   = wr_ready;
  assign cell_ce_o    = cell_en_q;
  assign cell_we_o    = cell_en_q;
  assign cell_tag_o   = cell_tag_q;
  assign cell_wdata_o = cell_wdata_q;
  assign occupied_o   = occ_vec;
  assign count_o      = count_q;
  assign full_o       = (count_q == CW'(NUM_CELLS));
  assign empty_o      = (count_q == '0);

endmodule

// File: doc/cache_tagmr_writer.md
CACHE_TAGMR_WRITER -- requirements
Module: cache_tagmr_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of stored data word.
REQ-002 SHALL have parameter TAG_ADDRESS_WIDTH, default 8, width of slot tag.
REQ-003 SHALL have parameter NUM_CELLS, default 4 (>=2), number of must-read cells driven.
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port wr_valid_i, input, 1, producer offers a write.
REQ-007 SHALL have port wr_ready_o, output, 1, block accepts the offered write this cycle.
REQ-008 SHALL have port wr_tag_i, input, TAG_ADDRESS_WIDTH, tag of the offered write.
REQ-009 SHALL have port wr_data_i, input, DATA_WIDTH, data of the offered write.
REQ-010 SHALL have port cell_ce_o, output, NUM_CELLS, per-cell chip enable, write cycles only.
REQ-011 SHALL have port cell_we_o, output, NUM_CELLS, per-cell write enable.
REQ-012 SHALL have port cell_tag_o, output, TAG_ADDRESS_WIDTH, tag broadcast to all cells.
REQ-013 SHALL have port cell_wdata_o, output, DATA_WIDTH, data broadcast to all cells.
REQ-014 SHALL have port cell_read_i, input, NUM_CELLS, per-cell has_been_read pulse from the cells.
REQ-015 SHALL have port occupied_o, output, NUM_CELLS, slot holds unread data (WRITING or HELD).
REQ-016 SHALL have port count_o, output, $clog2(NUM_CELLS+1), number of occupied slots.
REQ-017 SHALL have port full_o, output, 1, count_o == NUM_CELLS.
REQ-018 SHALL have port empty_o, output, 1, count_o == 0.

Function
REQ-019 SHALL keep per slot a registered state FREE, WRITING or HELD plus a registered TAG_ADDRESS_WIDTH tag.
REQ-020 SHALL define a handshake as wr_valid_i & wr_ready_o at a rising edge; at most one accept per cycle.
REQ-021 SHALL drive wr_ready_o combinationally from registered state only: 1 iff some slot is FREE and no WRITING/HELD slot stores a tag equal to wr_tag_i.
REQ-022 SHALL, on handshake, move the lowest-index FREE slot k to WRITING and register its tag, wr_tag_i and wr_data_i.
REQ-023 SHALL, in the cycle slot k is WRITING, assert cell_ce_o[k] = cell_we_o[k] = 1 (all other bits 0) with cell_tag_o/cell_wdata_o showing the accepted values (latency 1 cycle from handshake).
REQ-024 SHALL move a WRITING slot to HELD unconditionally after one cycle.
REQ-025 SHALL move a HELD slot to FREE on the edge where cell_read_i[k]=1; cell_read_i[k] SHALL be ignored in FREE and WRITING.
REQ-026 SHALL hold cell_ce_o/cell_we_o at 0 and cell_tag_o/cell_wdata_o at their last value when no slot is WRITING.
REQ-027 SHALL allow a slot freed on edge t to be re-accepted no earlier than the cycle following t; a freeing slot's tag still blocks duplicates in the freeing cycle.
REQ-028 SHALL update count_o by +1 on handshake, -1 per freed slot, summed in the same edge (net 0 when one accept and one free coincide).
REQ-029 SHALL never overwrite a WRITING or HELD slot (must-read guarantee); a stalled wr_valid_i producer SHALL see wr_ready_o=0 until a free, non-duplicate condition exists.

Reset
REQ-030 SHALL, while reset_n=0, force all slots FREE, tags 0, cell_ce_o=0, cell_we_o=0, cell_tag_o=0, cell_wdata_o=0, occupied_o=0, count_o=0, full_o=0, empty_o=1.
REQ-031 SHALL, on reset asserted mid-write, drop the in-flight write pulse immediately (asynchronous) and discard all held contents.
REQ-032 SHALL present wr_ready_o=1 in the first cycle after reset release when wr_valid_i=1.

Verification
REQ-033 Single write: tag 0x12 data 0xBEEF accepted at cycle t -> cycle t+1 cell_ce_o=cell_we_o=4'b0001, cell_tag_o=0x12, cell_wdata_o=0xBEEF; t+2 count_o=1, occupied_o=4'b0001.
REQ-034 Fill: four writes tags 1,2,3,4 back-to-back -> slots 0..3 in order, full_o=1, wr_ready_o=0 for fifth write tag 5 until a read pulse.
REQ-035 Duplicate tag: slot 0 HELD with tag 0x12, offer tag 0x12 -> wr_ready_o=0; pulse cell_read_i[0] -> next cycle wr_ready_o=1, write lands in slot 0.
REQ-036 Simultaneous: full, cell_read_i[2]=1 while wr_valid_i=1 tag 9 -> no accept that cycle; next cycle accept into slot 2, count_o stays 4 afterwards.
REQ-037 Read ignored: cell_read_i[1]=1 while slot 1 FREE or WRITING -> state unchanged, count_o unchanged.
REQ-038 Reset mid-operation: reset_n low during WRITING cycle -> cell_ce_o=0 immediately, count_o=0, empty_o=1, wr_ready_o=1 after release.
